// File: rtl/cache_req_decode_q_pkg.sv
// Shared types and width helpers for the buffered cache request decoder.
// Entry fields are sized for the largest supported geometry; narrower instances zero-extend.
package cache_req_decode_q_pkg;

    localparam int MAX_LINE_BYTES = 64;
    localparam int MAX_OFF_W      = 6;
    localparam int MAX_SET_W      = 10;
    localparam int MAX_ADDR_W     = 64;
    localparam int MAX_IDX_W      = 16;

    function automatic int f_off_w(input int line_bytes);
        return $clog2(line_bytes);
    endfunction

    function automatic int f_set_w(input int num_sets);
        return $clog2(num_sets);
    endfunction

    function automatic int f_tag_w(input int addr_w, input int line_bytes, input int num_sets);
        return addr_w - f_off_w(line_bytes) - f_set_w(num_sets);
    endfunction

    typedef struct packed {
        logic [MAX_ADDR_W-1:0]       tag;
        logic [MAX_SET_W-1:0]        set_idx;
        logic [MAX_OFF_W-1:0]        offset;
        logic                        csb;
        logic                        web;
        logic [MAX_LINE_BYTES-1:0]   line_wmask;
        logic [8*MAX_LINE_BYTES-1:0] line_wdata;
        logic [3:0]                  rmask;
        logic [3:0]                  wmask;
        logic [31:0]                 wdata;
        logic [MAX_ADDR_W-1:0]       addr;
        logic [MAX_IDX_W-1:0]        index;
        logic                        err;
    } dec_req_t;

endpackage

// File: rtl/cache_req_decode_comb.sv
// Combinational decode of one LSQ request into a cache-line-oriented entry.
// Illegal byte lanes are those at or above 4 - addr[1:0] within the addressed word.
module cache_req_decode_comb
    import cache_req_decode_q_pkg::*;
#(
    parameter int LINE_BYTES = 32,
    parameter int NUM_SETS   = 16,
    parameter int ADDR_W     = 32,
    parameter int IDX_W      = 4
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [3:0]        rmask,
    input  logic [3:0]        wmask,
    input  logic [31:0]       wdata,
    input  logic [IDX_W-1:0]  index,
    output dec_req_t          dec,
    output logic              is_null
);

    localparam int OFF_W = f_off_w(LINE_BYTES);
    localparam int SET_W = f_set_w(NUM_SETS);
    localparam int TAG_W = f_tag_w(ADDR_W, LINE_BYTES, NUM_SETS);

    logic [OFF_W-1:0] off;
    logic [OFF_W-1:0] word_sel;
    logic [3:0]       lane_ok;
    logic             any_r;
    logic             any_w;
    logic             misalign;

    always_comb begin
        off      = addr[OFF_W-1:0];
        word_sel = off >> 2;
        any_r    = |rmask;
        any_w    = |wmask;
        lane_ok  = 4'hF >> addr[1:0];
        misalign = |((rmask | wmask) & ~lane_ok);
        is_null  = !(any_r || any_w);

        dec            = '0;
        dec.tag        = MAX_ADDR_W'(addr[ADDR_W-1 -: TAG_W]);
        dec.set_idx    = MAX_SET_W'(addr[OFF_W+SET_W-1:OFF_W]);
        dec.offset     = MAX_OFF_W'(off);
        // Lane placement by shift keeps every non-addressed lane at zero.
        dec.line_wmask = MAX_LINE_BYTES'(wmask) << {word_sel, 2'b00};
        dec.line_wdata = (8*MAX_LINE_BYTES)'(wdata) << {word_sel, 5'b00000};
        dec.err        = (any_r && any_w) || misalign;
        dec.csb        = is_null || dec.err;
        dec.web        = !any_w;
        dec.rmask      = rmask;
        dec.wmask      = wmask;
        dec.wdata      = wdata;
        dec.addr       = MAX_ADDR_W'(addr);
        dec.index      = MAX_IDX_W'(index);
    end

endmodule

// File: rtl/cache_req_decode_q.sv
// Cache request decoder with a 2-entry skid FIFO between the LSQ and cache stage 1.
// req_ready comes only from the registered count, so there is no comb path from out_ready.
module cache_req_decode_q
    import cache_req_decode_q_pkg::*;
#(
    parameter int LINE_BYTES = 32,
    parameter int NUM_SETS   = 16,
    parameter int ADDR_W     = 32,
    parameter int IDX_W      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [3:0]        req_rmask,
    input  logic [3:0]        req_wmask,
    input  logic [31:0]       req_wdata,
    input  logic [IDX_W-1:0]  req_index,
    output logic              out_valid,
    input  logic              out_ready,
    output dec_req_t          out
);

    dec_req_t   dec;
    logic       dec_null;
    dec_req_t   mem_q [2];
    dec_req_t   mem_d [2];
    logic       head_q, head_d;
    logic       tail_q, tail_d;
    logic [1:0] count_q, count_d;
    logic       enq;
    logic       deq;

    cache_req_decode_comb #(
        .LINE_BYTES (LINE_BYTES),
        .NUM_SETS   (NUM_SETS),
        .ADDR_W     (ADDR_W),
        .IDX_W      (IDX_W)
    ) u_decode (
        .addr    (req_addr),
        .rmask   (req_rmask),
        .wmask   (req_wmask),
        .wdata   (req_wdata),
        .index   (req_index),
        .dec     (dec),
        .is_null (dec_null)
    );

    always_comb begin
        req_ready = (count_q != 2'd2);
        out_valid = (count_q != 2'd0);
        // Null requests complete the handshake but never occupy a slot.
        enq       = req_valid && req_ready && !dec_null;
        deq       = out_valid && out_ready;

        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = 1'b0;
            tail_d  = 1'b0;
            count_d = 2'd0;
        end else begin
            if (enq) begin
                mem_d[tail_q] = dec;
                tail_d        = ~tail_q;
            end
            if (deq) begin
                head_d = ~head_q;
            end
            count_d = count_q + {1'b0, enq} - {1'b0, deq};
        end
    end

    assign out = mem_q[head_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q   <= 1'b0;
            tail_q   <= 1'b0;
            count_q  <= 2'd0;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            mem_q   <= mem_d;
        end
    end

endmodule

// File: tb/tb_cache_req_decode_q.sv
// Bench for cache_req_decode_q: two geometries driven in parallel against a queue-based model.
module tb_cache_req_decode_q;
    import cache_req_decode_q_pkg::*;

    localparam int AW = 32;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          rst, flush, req_valid, out_ready;
    logic [AW-1:0] req_addr;
    logic [3:0]    req_rmask, req_wmask;
    logic [31:0]   req_wdata;
    logic [IW-1:0] req_index;
    logic          rdy_a, vld_a, rdy_b, vld_b;
    dec_req_t      out_a, out_b;

    int n_cmp  = 0;
    int n_fail = 0;
    bit check_en = 1'b0;
    dec_req_t exp_a[$];
    dec_req_t exp_b[$];
    dec_req_t zero_e;

    always #5 clk = ~clk;

    cache_req_decode_q #(.LINE_BYTES(32), .NUM_SETS(16), .ADDR_W(AW), .IDX_W(IW)) u_dut_a (
        .clk(clk), .rst(rst), .flush(flush), .req_valid(req_valid), .req_ready(rdy_a),
        .req_addr(req_addr), .req_rmask(req_rmask), .req_wmask(req_wmask), .req_wdata(req_wdata),
        .req_index(req_index), .out_valid(vld_a), .out_ready(out_ready), .out(out_a)
    );

    cache_req_decode_q #(.LINE_BYTES(64), .NUM_SETS(8), .ADDR_W(AW), .IDX_W(IW)) u_dut_b (
        .clk(clk), .rst(rst), .flush(flush), .req_valid(req_valid), .req_ready(rdy_b),
        .req_addr(req_addr), .req_rmask(req_rmask), .req_wmask(req_wmask), .req_wdata(req_wdata),
        .req_index(req_index), .out_valid(vld_b), .out_ready(out_ready), .out(out_b)
    );

    // Expected entry from address arithmetic rather than bit slicing.
    function automatic dec_req_t model(input logic [31:0] addr, input logic [3:0] rm, input logic [3:0] wm,
                                       input logic [31:0] wd, input logic [IW-1:0] idx,
                                       input int lb, input int ns);
        dec_req_t          e;
        longint unsigned   a;
        longint unsigned   lbn;
        int                off, set, w, a_lo;
        bit                bad;
        e    = '0;
        a    = 64'(addr);
        lbn  = 64'(lb * ns);
        off  = int'(a % 64'(lb));
        set  = int'((a / 64'(lb)) % 64'(ns));
        w    = off / 4;
        a_lo = int'(a % 64'd4);
        e.tag     = a / lbn;
        e.set_idx = MAX_SET_W'(set);
        e.offset  = MAX_OFF_W'(off);
        for (int b = 0; b < 4; b++) begin
            if (wm[b]) e.line_wmask[4*w+b] = 1'b1;
        end
        e.line_wdata[32*w +: 32] = wd;
        bad = 1'b0;
        for (int b = 0; b < 4; b++) begin
            if ((rm[b] || wm[b]) && b >= 4 - a_lo) bad = 1'b1;
        end
        e.err   = ((rm != 4'd0) && (wm != 4'd0)) || bad;
        e.csb   = ((rm == 4'd0) && (wm == 4'd0)) || e.err;
        e.web   = (wm == 4'd0);
        e.rmask = rm;
        e.wmask = wm;
        e.wdata = wd;
        e.addr  = a;
        e.index = MAX_IDX_W'(idx);
        return e;
    endfunction

    task automatic cmp_bit(input string nm, input logic act, input logic req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%b required=%b", nm, act, req);
        end
    endtask

    task automatic cmp_val(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic cmp_ent(input string nm, input dec_req_t act, input dec_req_t req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual tag=%h set=%h off=%h lwm=%h err=%b csb=%b web=%b idx=%h wd=%h / required tag=%h set=%h off=%h lwm=%h err=%b csb=%b web=%b idx=%h wd=%h",
                     nm, act.tag, act.set_idx, act.offset, act.line_wmask, act.err, act.csb, act.web, act.index, act.wdata,
                     req.tag, req.set_idx, req.offset, req.line_wmask, req.err, req.csb, req.web, req.index, req.wdata);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        bit nul, acc_a, acc_b;
        nul   = (req_rmask == 4'd0) && (req_wmask == 4'd0);
        acc_a = req_valid && (exp_a.size() < 2);
        acc_b = req_valid && (exp_b.size() < 2);
        if (rst || flush) begin
            exp_a.delete();
            exp_b.delete();
        end else begin
            if (exp_a.size() > 0 && out_ready) void'(exp_a.pop_front());
            if (exp_b.size() > 0 && out_ready) void'(exp_b.pop_front());
            if (acc_a && !nul) exp_a.push_back(model(req_addr, req_rmask, req_wmask, req_wdata, req_index, 32, 16));
            if (acc_b && !nul) exp_b.push_back(model(req_addr, req_rmask, req_wmask, req_wdata, req_index, 64, 8));
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            cmp_bit("a.out_valid", vld_a, exp_a.size() != 0);
            cmp_bit("a.req_ready", rdy_a, exp_a.size() < 2);
            if (exp_a.size() != 0) cmp_ent("a.out", out_a, exp_a[0]);
            cmp_bit("b.out_valid", vld_b, exp_b.size() != 0);
            cmp_bit("b.req_ready", rdy_b, exp_b.size() < 2);
            if (exp_b.size() != 0) cmp_ent("b.out", out_b, exp_b[0]);
        end
    end

    task automatic drive(input logic v, input logic [31:0] addr, input logic [3:0] rm, input logic [3:0] wm,
                         input logic [31:0] wd, input logic [IW-1:0] idx);
        req_valid = v;
        req_addr  = addr;
        req_rmask = rm;
        req_wmask = wm;
        req_wdata = wd;
        req_index = idx;
    endtask

    initial begin
        logic [511:0] lane_mask;
        logic [31:0]  wd;
        int           pick;
        zero_e    = '0;
        rst       = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 32'h0, 4'h0, 4'h0, 32'h0, 4'h0);

        step();
        check_en = 1'b1;
        step();
        cmp_bit("rst.req_ready", rdy_a, 1'b1);
        cmp_bit("rst.out_valid", vld_a, 1'b0);
        cmp_ent("rst.out_zero", out_a, zero_e);
        rst = 1'b0;
        step();

        // Single store; visible next cycle even with out_ready low.
        out_ready = 1'b0;
        drive(1'b1, 32'h0000_1234, 4'h0, 4'hF, 32'hDEAD_BEEF, 4'd5);
        step();
        drive(1'b0, 32'h0, 4'h0, 4'h0, 32'h0, 4'h0);
        cmp_bit("t1.out_valid", vld_a, 1'b1);
        cmp_val("t1.tag", out_a.tag, 64'h9);
        cmp_val("t1.set_idx", 64'(out_a.set_idx), 64'h1);
        cmp_val("t1.offset", 64'(out_a.offset), 64'h14);
        cmp_val("t1.line_wmask", out_a.line_wmask, 64'h0000_0000_00F0_0000);
        cmp_val("t1.lane5", 64'(out_a.line_wdata[191:160]), 64'hDEAD_BEEF);
        lane_mask = 512'hFFFF_FFFF;
        lane_mask = lane_mask << 160;
        cmp_val("t1.other_lanes", 64'((out_a.line_wdata & ~lane_mask) != 512'd0), 64'd0);
        cmp_bit("t1.web", out_a.web, 1'b0);
        cmp_bit("t1.csb", out_a.csb, 1'b0);
        cmp_val("t1b.tag", out_b.tag, 64'h9);
        cmp_val("t1b.set_idx", 64'(out_b.set_idx), 64'h0);
        cmp_val("t1b.offset", 64'(out_b.offset), 64'h34);
        cmp_val("t1b.line_wmask", out_b.line_wmask, 64'h00F0_0000_0000_0000);
        cmp_val("t1b.lane13", 64'(out_b.line_wdata[447:416]), 64'hDEAD_BEEF);
        out_ready = 1'b1;
        step();

        // Lane placement for every word of the 64-byte line.
        for (int w = 0; w < 16; w++) begin
            wd = 32'hA500_0000 | 32'(w);
            drive(1'b1, 32'h0000_1000 + 32'(4*w), 4'h0, 4'hF, wd, 4'(w));
            step();
            cmp_val("lane.wmask", out_b.line_wmask, 64'hF << (4*w));
            cmp_val("lane.wdata", 64'(out_b.line_wdata[32*w +: 32]), 64'(wd));
        end
        drive(1'b0, 32'h0, 4'h0, 4'h0, 32'h0, 4'h0);
        step();

        // Aligned and misaligned halfword loads.
        drive(1'b1, 32'h0000_0102, 4'h3, 4'h0, 32'h0, 4'd1);
        step();
        cmp_val("ld102.line_wmask", out_a.line_wmask, 64'h0);
        cmp_bit("ld102.web", out_a.web, 1'b1);
        cmp_bit("ld102.csb", out_a.csb, 1'b0);
        cmp_bit("ld102.err", out_a.err, 1'b0);
        drive(1'b1, 32'h0000_0103, 4'h3, 4'h0, 32'h0, 4'd2);
        step();
        cmp_bit("ld103.err", out_a.err, 1'b1);
        cmp_bit("ld103.csb", out_a.csb, 1'b1);
        drive(1'b0, 32'h0, 4'h0, 4'h0, 32'h0, 4'h0);
        step();

        // Backpressure: two accepted, third waits for the first dequeue.
        out_ready = 1'b0;
        drive(1'b1, 32'h40, 4'hF, 4'h0, 32'h0, 4'd1);
        step();
        drive(1'b1, 32'h44, 4'hF, 4'h0, 32'h0, 4'd2);
        step();
        drive(1'b1, 32'h48, 4'hF, 4'h0, 32'h0, 4'd3);
        cmp_bit("bp.ready_full", rdy_a, 1'b0);
        step();
        cmp_bit("bp.ready_hold", rdy_a, 1'b0);
        cmp_val("bp.head1", 64'(out_a.index), 64'd1);
        out_ready = 1'b1;
        step();
        cmp_bit("bp.ready_rise", rdy_a, 1'b1);
        cmp_val("bp.head2", 64'(out_a.index), 64'd2);
        step();
        drive(1'b0, 32'h0, 4'h0, 4'h0, 32'h0, 4'h0);
        cmp_val("bp.head3", 64'(out_a.index), 64'd3);
        step();
        cmp_bit("bp.drained", vld_a, 1'b0);

        // Null request is accepted but not stored; both masks set is an error.
        drive(1'b1, 32'h80, 4'h0, 4'h0, 32'h0, 4'd4);
        cmp_bit("null.ready", rdy_a, 1'b1);
        step();
        cmp_bit("null.out_valid", vld_a, 1'b0);
        drive(1'b1, 32'h80, 4'h1, 4'h1, 32'h0, 4'd5);
        step();
        cmp_bit("both.err", out_a.err, 1'b1);
        drive(1'b0, 32'h0, 4'h0, 4'h0, 32'h0, 4'h0);
        step();

        // Flush while full with a request offered.
        out_ready = 1'b0;
        drive(1'b1, 32'hC0, 4'hF, 4'h0, 32'h0, 4'd6);
        step();
        drive(1'b1, 32'hC4, 4'hF, 4'h0, 32'h0, 4'd7);
        step();
        drive(1'b1, 32'hC8, 4'hF, 4'h0, 32'h0, 4'd9);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, 32'h0, 4'h0, 4'h0, 32'h0, 4'h0);
        cmp_bit("flush.out_valid", vld_a, 1'b0);
        cmp_bit("flush.ready", rdy_a, 1'b1);
        step();
        cmp_bit("flush.dropped", vld_a, 1'b0);

        // Randomized traffic with occasional flush and reset.
        for (int i = 0; i < 3000; i++) begin
            pick      = int'($urandom_range(0, 7));
            rst       = ($urandom_range(0, 199) == 0);
            flush     = ($urandom_range(0, 49) == 0);
            out_ready = ($urandom_range(0, 9) < 6);
            req_valid = ($urandom_range(0, 9) < 7);
            req_addr  = $urandom;
            req_wdata = $urandom;
            req_index = 4'($urandom);
            case (pick)
                0:       begin req_rmask = 4'h0;          req_wmask = 4'h0;          end
                1:       begin req_rmask = 4'($urandom);  req_wmask = 4'($urandom);  end
                2, 3, 4: begin req_rmask = 4'h0;          req_wmask = 4'($urandom);  end
                default: begin req_rmask = 4'($urandom);  req_wmask = 4'h0;          end
            endcase
            step();
        end
        rst = 1'b0;
        flush = 1'b0;
        drive(1'b0, 32'h0, 4'h0, 4'h0, 32'h0, 4'h0);
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
